rect_plotter: RTL

RECT_PLOTTER -- requirements
Module: rect_plotter

---
 rtl/rect_plotter_pkg.sv | 22 ++
 rtl/rect_scan_counter.sv | 66 ++++++
 rtl/rect_plotter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/rect_plotter_pkg.sv
`default_nettype none
// ============================================================================
//  Module : rect_plotter_pkg
//  Brief  : Shared constants for the rectangle plotter: drawing-mode
//           encoding and the controller state encoding.
//  Rev    : 1.0  initial release
// ============================================================================
package rect_plotter_pkg;

    // Drawing modes as presented on the mode port. 2'b11 falls through to fill.
    localparam logic [1:0] MODE_FILL    = 2'b00;
    localparam logic [1:0] MODE_OUTLINE = 2'b01;
    localparam logic [1:0] MODE_ERASE   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

endpackage : rect_plotter_pkg
`default_nettype wire

// File: rtl/rect_scan_counter.sv
`default_nettype none
// ============================================================================
//  Module : rect_scan_counter
//  Brief  : Row-major position counter for the rectangle scan. cx runs
//           0..width-1 fastest, cy runs 0..height-1.
//  Ports  : clk, reset (async, active-high)
//           clear   - return both counters to 0
//           advance - step to the next position
//           width, height - registered rectangle size
//           cx, cy  - current position; last - position is the final one
//  Rev    : 1.0  initial release
// ============================================================================
module rect_scan_counter #(
    parameter int DIM_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             advance,
    input  logic [DIM_W-1:0] width,
    input  logic [DIM_W-1:0] height,
    output logic [DIM_W-1:0] cx,
    output logic [DIM_W-1:0] cy,
    output logic             last
);

    logic [DIM_W-1:0] cx_q, cx_d;
    logic [DIM_W-1:0] cy_q, cy_d;
    logic [DIM_W-1:0] w_x_max;
    logic [DIM_W-1:0] w_y_max;

    assign w_x_max = width  - DIM_W'(1);
    assign w_y_max = height - DIM_W'(1);

    always_comb begin
        cx_d = cx_q;
        cy_d = cy_q;
        if (clear) begin
            cx_d = '0;
            cy_d = '0;
        end else if (advance) begin
            if (cx_q == w_x_max) begin
                cx_d = '0;
                cy_d = cy_q + DIM_W'(1);
            end else begin
                cx_d = cx_q + DIM_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cx_q <= '0;
            cy_q <= '0;
        end else begin
            cx_q <= cx_d;
            cy_q <= cy_d;
        end
    end

    assign cx   = cx_q;
    assign cy   = cy_q;
    assign last = (cx_q == w_x_max) && (cy_q == w_y_max);

endmodule : rect_scan_counter
`default_nettype wire

// File: rtl/rect_plotter.sv
`default_nettype none
// ============================================================================
//  Module : rect_plotter
//  Brief  : Streams the pixels of an axis-aligned rectangle (fill, outline
//           or erase) with screen clipping and a valid/ready pixel handshake.
//  Ports  : clk, reset (async, active-high)
//           start_valid/start_ready - request handshake (ready only in IDLE)
//           x_in, y_in, width, height, c_in, mode - request fields
//           plot/pixel_ready - pixel handshake; x_out, y_out, c_out - pixel
//           busy - not IDLE; done - one-cycle completion pulse
//  Rev    : 1.0  initial release
// ============================================================================
module rect_plotter
    import rect_plotter_pkg::*;
#(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int DIM_W    = 5,
    parameter int C_W      = 3,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [X_W-1:0]   x_in,
    input  logic [Y_W-1:0]   y_in,
    input  logic [DIM_W-1:0] width,
    input  logic [DIM_W-1:0] height,
    input  logic [C_W-1:0]   c_in,
    input  logic [1:0]       mode,
    output logic             plot,
    input  logic             pixel_ready,
    output logic [X_W-1:0]   x_out,
    output logic [Y_W-1:0]   y_out,
    output logic [C_W-1:0]   c_out,
    output logic             busy,
    output logic             done
);

    state_t           state_q, state_d;
    logic [X_W-1:0]   x0_q, x0_d;
    logic [Y_W-1:0]   y0_q, y0_d;
    logic [DIM_W-1:0] w_q, w_d;
    logic [DIM_W-1:0] h_q, h_d;
    logic [C_W-1:0]   c_q, c_d;
    logic [1:0]       mode_q, mode_d;

    logic             w_clear;
    logic             w_advance;
    logic             w_last;
    logic [DIM_W-1:0] w_cx;
    logic [DIM_W-1:0] w_cy;
    logic [X_W:0]     w_x_sum;
    logic [Y_W:0]     w_y_sum;
    logic             w_on_edge;
    logic             w_visible;

    rect_scan_counter #(
        .DIM_W (DIM_W)
    ) u_scan (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_clear),
        .advance (w_advance),
        .width   (w_q),
        .height  (h_q),
        .cx      (w_cx),
        .cy      (w_cy),
        .last    (w_last)
    );

    // One extra bit keeps the carry so positions past the screen edge are
    // recognised as clipped rather than wrapping back onto the screen.
    assign w_x_sum   = {1'b0, x0_q} + (X_W+1)'(w_cx);
    assign w_y_sum   = {1'b0, y0_q} + (Y_W+1)'(w_cy);
    assign w_on_edge = (w_cx == '0) || (w_cx == w_q - DIM_W'(1)) ||
                       (w_cy == '0) || (w_cy == h_q - DIM_W'(1));
    assign w_visible = (w_x_sum < (X_W+1)'(SCREEN_W)) &&
                       (w_y_sum < (Y_W+1)'(SCREEN_H)) &&
                       ((mode_q != MODE_OUTLINE) || w_on_edge);

    always_comb begin
        state_d   = state_q;
        x0_d      = x0_q;
        y0_d      = y0_q;
        w_d       = w_q;
        h_d       = h_q;
        c_d       = c_q;
        mode_d    = mode_q;
        w_clear   = 1'b0;
        w_advance = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_valid) begin
                    x0_d    = x_in;
                    y0_d    = y_in;
                    w_d     = width;
                    h_d     = height;
                    c_d     = (mode == MODE_ERASE) ? '0 : c_in;
                    mode_d  = mode;
                    w_clear = 1'b1;
                    // Empty rectangles skip straight to completion.
                    state_d = ((width == '0) || (height == '0)) ? ST_FIN : ST_DRAW;
                end
            end
            ST_DRAW: begin
                // Clipped / interior positions never wait on the downstream.
                w_advance = !w_visible || pixel_ready;
                if (w_advance && w_last) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            x0_q    <= '0;
            y0_q    <= '0;
            w_q     <= '0;
            h_q     <= '0;
            c_q     <= '0;
            mode_q  <= '0;
        end else begin
            state_q <= state_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            w_q     <= w_d;
            h_q     <= h_d;
            c_q     <= c_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        plot  = 1'b0;
        x_out = '0;
        y_out = '0;
        c_out = '0;
        if (state_q == ST_DRAW) begin
            plot  = w_visible;
            x_out = w_x_sum[X_W-1:0];
            y_out = w_y_sum[Y_W-1:0];
            c_out = c_q;
        end
    end

    assign start_ready = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_FIN);

endmodule : rect_plotter
`default_nettype wire
